// File: rtl/enc8to3_rr.sv
// Registered 8-to-3 request encoder/arbiter with active-low requests, round-robin
// or fixed-priority search, and a valid/ack handshake on the held grant.
module enc8to3_rr #(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic       enb_,
   input  logic [7:0] req_,
   input  logic       ack,
   output logic       vld,
   output logic [2:0] sel,
   output logic [7:0] gnt_,
   output logic       multi
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q;
   logic [2:0] ptr_q;
   logic       vld_q;
   logic [2:0] sel_q;
   logic [7:0] gnt_q;
   logic       multi_q;

   logic [2:0] scan_ptr_d;
   logic       hit_d;
   logic [2:0] win_d;
   logic [3:0] cnt_d;
   logic       many_d;
   logic       arb_ok_d;

   function automatic logic [7:0] onehot_n(input logic [2:0] idx);
      logic [7:0] v;
      v = 8'hFF;
      v[idx] = 1'b0;
      return v;
   endfunction

   // A grant being acked re-arbitrates from the line after it; idle searches use the stored pointer.
   always_comb begin
      scan_ptr_d = ptr_q;
      if (state_q == GRANT) begin
         scan_ptr_d = RR_EN ? (sel_q + 3'd1) : 3'd0;
      end
   end

   always_comb begin
      hit_d = 1'b0;
      win_d = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (!hit_d && !req_[scan_ptr_d + 3'(k)]) begin
            hit_d = 1'b1;
            win_d = scan_ptr_d + 3'(k);
         end
      end
   end

   always_comb begin
      cnt_d = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt_d = cnt_d + {3'b000, ~req_[i]};
      end
      many_d   = (cnt_d > 4'd1);
      arb_ok_d = !enb_ && hit_d;
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         vld_q   <= 1'b0;
         sel_q   <= 3'd0;
         gnt_q   <= 8'hFF;
         multi_q <= 1'b0;
      end else if (state_q == IDLE) begin
         if (arb_ok_d) begin
            state_q <= GRANT;
            vld_q   <= 1'b1;
            sel_q   <= win_d;
            gnt_q   <= onehot_n(win_d);
            multi_q <= many_d;
         end
      end else if (ack) begin
         // Without ack the grant is frozen, whatever req_ and enb_ do.
         ptr_q <= scan_ptr_d;
         if (arb_ok_d) begin
            vld_q   <= 1'b1;
            sel_q   <= win_d;
            gnt_q   <= onehot_n(win_d);
            multi_q <= many_d;
         end else begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            gnt_q   <= 8'hFF;
            multi_q <= 1'b0;
         end
      end
   end

   assign vld   = vld_q;
   assign sel   = sel_q;
   assign gnt_  = gnt_q;
   assign multi = multi_q;

endmodule

// File: tb/tb_enc8to3_rr.sv
// Scoreboard bench for enc8to3_rr: a round-robin and a fixed-priority instance
// share stimulus; expected {vld,sel,gnt_,multi} words are queued and popped per edge.
module tb_enc8to3_rr;

   logic       clk = 1'b0;
   logic       rst_;
   logic       enb_;
   logic [7:0] req_;
   logic       ack;

   logic       vld_rr, multi_rr, vld_fp, multi_fp;
   logic [2:0] sel_rr, sel_fp;
   logic [7:0] gnt_rr, gnt_fp;

   int total = 0;
   int bad   = 0;

   logic [12:0] exp_q[$];
   logic [12:0] got, want;
   logic [12:0] idle_w;

   always #5 clk = ~clk;

   enc8to3_rr #(.RR_EN(1'b1)) dut_rr (
      .clk(clk), .rst_(rst_), .enb_(enb_), .req_(req_), .ack(ack),
      .vld(vld_rr), .sel(sel_rr), .gnt_(gnt_rr), .multi(multi_rr)
   );

   enc8to3_rr #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst_(rst_), .enb_(enb_), .req_(req_), .ack(ack),
      .vld(vld_fp), .sel(sel_fp), .gnt_(gnt_fp), .multi(multi_fp)
   );

   wire [12:0] out_rr = {vld_rr, sel_rr, gnt_rr, multi_rr};
   wire [12:0] out_fp = {vld_fp, sel_fp, gnt_fp, multi_fp};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      ack  = 1'b0;
      enb_ = 1'b1;
      req_ = 8'hFF;
      rst_ = 1'b0;
      step();
      rst_ = 1'b1;
   endtask

   task automatic test_reset();
      rst_ = 1'b0; enb_ = 1'b1; req_ = 8'hFF; ack = 1'b0;
      step();
      exp_q.push_back({1'b0, 3'd0, 8'hFF, 1'b0});
      got = out_rr; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset_init got=%h want=%h", got, want); end
      rst_ = 1'b1;
      enb_ = 1'b0; req_ = 8'b1111_0111;
      exp_q.push_back({1'b1, 3'd3, 8'b1111_0111, 1'b0});
      step();
      got = out_rr; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset_pregrant got=%h want=%h", got, want); end
      @(negedge clk);
      #1;
      rst_ = 1'b0;
      exp_q.push_back({1'b0, 3'd0, 8'hFF, 1'b0});
      #1;
      got = out_rr; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset_async got=%h want=%h", got, want); end
      @(posedge clk);
      #1;
      req_ = 8'hFF; enb_ = 1'b0;
      rst_ = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back({1'b0, 3'd0, 8'hFF, 1'b0});
         step();
         got = out_rr; want = exp_q.pop_front(); total++;
         if (got !== want) begin bad++; $display("FAIL reset_after%0d got=%h want=%h", i, got, want); end
      end
   endtask

   task automatic test_fixed_priority();
      apply_reset();
      enb_ = 1'b0; req_ = 8'b1111_0101;
      exp_q.push_back({1'b1, 3'd1, 8'b1111_1101, 1'b1});
      step();
      got = out_fp; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL fp_first got=%h want=%h", got, want); end
      ack = 1'b1;
      step();
      ack = 1'b0;
      exp_q.push_back({1'b1, 3'd1, 8'b1111_1101, 1'b1});
      exp_q.push_back({1'b1, 3'd3, 8'b1111_0111, 1'b1});
      got = out_fp; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL fp_regrant got=%h want=%h", got, want); end
      got = out_rr; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL rr_vs_fp got=%h want=%h", got, want); end
   endtask

   task automatic test_round_robin();
      logic [7:0] reqs [4] = '{8'b0111_1110, 8'b0111_1110, 8'b0111_1110, 8'hFF};
      logic       acks [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      apply_reset();
      enb_ = 1'b0;
      exp_q.push_back({1'b1, 3'd0, 8'b1111_1110, 1'b1});
      exp_q.push_back({1'b1, 3'd7, 8'b0111_1111, 1'b1});
      exp_q.push_back({1'b1, 3'd0, 8'b1111_1110, 1'b1});
      exp_q.push_back({1'b0, 3'd0, 8'hFF, 1'b0});
      for (int i = 0; i < 4; i++) begin
         req_ = reqs[i]; ack = acks[i];
         step();
         got = out_rr; want = exp_q.pop_front(); total++;
         if (got !== want) begin bad++; $display("FAIL rr_wrap%0d got=%h want=%h", i, got, want); end
      end
      ack = 1'b0;
   endtask

   task automatic test_hold_enable();
      apply_reset();
      enb_ = 1'b0; req_ = 8'b1110_1111;
      step();
      req_ = 8'hFF; enb_ = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back({1'b1, 3'd4, 8'b1110_1111, 1'b0});
         got = out_rr; want = exp_q.pop_front(); total++;
         if (got !== want) begin bad++; $display("FAIL hold%0d got=%h want=%h", i, got, want); end
         if (i < 5) step();
      end
      ack = 1'b1;
      exp_q.push_back({1'b0, 3'd4, 8'hFF, 1'b0});
      step();
      got = out_rr; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL hold_release got=%h want=%h", got, want); end
      req_ = 8'h00;
      for (int i = 0; i < 3; i++) begin
         ack = (i == 1);
         exp_q.push_back({1'b0, 3'd4, 8'hFF, 1'b0});
         step();
         got = out_rr; want = exp_q.pop_front(); total++;
         if (got !== want) begin bad++; $display("FAIL enb_block%0d got=%h want=%h", i, got, want); end
      end
      ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      enb_ = 1'b0; req_ = 8'h00; ack = 1'b1;
      for (int i = 0; i < 9; i++) begin
         logic [2:0] s;
         s = 3'(i);
         exp_q.push_back({1'b1, s, ~(8'b1 << s), 1'b1});
      end
      for (int i = 0; i < 9; i++) begin
         step();
         got = out_rr; want = exp_q.pop_front(); total++;
         if (got !== want) begin bad++; $display("FAIL b2b%0d got=%h want=%h", i, got, want); end
      end
      ack = 1'b0;
   endtask

   task automatic test_single();
      logic [7:0] dec;
      apply_reset();
      enb_ = 1'b0; req_ = 8'b1101_1111;
      exp_q.push_back({1'b1, 3'd5, 8'b1101_1111, 1'b0});
      step();
      got = out_rr; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL single got=%h want=%h", got, want); end
      dec = 8'hFF;
      dec[sel_rr] = 1'b0;
      total++;
      if (dec !== gnt_rr) begin bad++; $display("FAIL decode got=%h want=%h", gnt_rr, dec); end
      ack = 1'b1;
      exp_q.push_back({1'b1, 3'd5, 8'b1101_1111, 1'b0});
      step();
      got = out_rr; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL single_regrant got=%h want=%h", got, want); end
      ack = 1'b0;
   endtask

   initial begin
      idle_w = '0;
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_hold_enable();
      test_back_to_back();
      test_single();
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL queue_left got=%0d want=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/enc8to3_rr.md
Name: enc8to3_rr

Overview:
- Registered 8-to-3 request encoder and arbiter. It takes active-low one-hot or multi-hot request lines and produces a 3-bit select code with a valid/ack handshake.
- It is the encoding counterpart of the team's active-low 3-to-8 decoder. The sel and gnt_ outputs have the same encoding as that decoder's inputs and outputs, so sel can drive the decoder directly.
- Its job is to collapse eight active-low request/interrupt lines into one granted index for downstream logic.

Parameters:
- RR_EN, default 1, priority mode.
  - 1: round-robin; the search starts at the line after the last acknowledged grant.
  - 0: fixed priority; line 0 is highest and the pointer stays at 0.

Ports:
- clk  input  1  rising-edge clock.
- rst_  input  1  asynchronous active-low reset.
- enb_  input  1  active-low arbitration enable. High blocks new grants.
- req_  input  8  active-low requests. Bit i low means line i requests.
- ack  input  1  active-high. Consumer accepts the current grant.
- vld  output  1  a grant is held on sel/gnt_.
- sel  output  3  encoded index of the granted line.
- gnt_  output  8  active-low one-hot of the granted line. All ones when vld=0.
- multi  output  1  more than one request was low when the current grant was taken (registered with the grant).

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-low (rst_).
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset values (asserted immediately, independent of clk):
  - vld=0, sel=3'b000, gnt_=8'hFF, multi=0.
  - Internal pointer ptr=3'd0; state=IDLE.
- Reset mid-grant drops vld at once. The pending grant is lost and is not replayed.
- Requests are level-sensitive, sampled on every rising edge. No synchronisation is done inside the block; inputs must already be in the clk domain.
- Winner search:
  - Scan order is ptr, ptr+1, …, ptr+7, modulo 8, with wrap 7 to 0.
  - The first index with req_[i]=0 wins.
  - When RR_EN=0, ptr is held at 0, giving plain priority where the lowest index wins.
- States:
  - IDLE:
    - When enb_=0 and any req_ bit is 0 at edge n, the winner is registered at edge n.
    - vld=1, sel=winner, gnt_ low only at bit winner, multi=(count of low bits >1). The block then goes to GRANT. Latency is one cycle.
    - Otherwise the block stays in IDLE and the outputs keep their idle values.
  - GRANT:
    - sel, gnt_ and multi are held stable while ack=0, regardless of req_ or enb_ changes. A withdrawn request is still held, and raising enb_ does not abort the grant.
    - When ack=1 at an edge:
      - ptr <= sel+1 (mod 8) if RR_EN=1.
      - The block re-arbitrates in the same edge using the new ptr, current req_ and current enb_.
      - If there is a winner, the new grant is loaded and vld stays 1. This gives back-to-back grants at one per cycle when ack is held high.
      - If there is no winner, vld=0, gnt_=8'hFF, sel is held at its last value, multi=0, and the block goes to IDLE.
- ack while vld=0 is ignored: no pointer change, no error.
- A request held continuously, with ack given each cycle, is re-granted only after every other active line has been served once (RR_EN=1). This bounds starvation at 7 grants.
- Arithmetic: ptr and sel are 3-bit and wrap naturally; the scan index is (ptr+k) mod 8 for k=0..7.
- X on req_ or enb_ is not required to be handled. The bench drives clean values only.

Test Plan:
- Reset check: assert rst_=0 asynchronously mid-cycle with a grant pending → vld=0, gnt_=8'hFF and sel=0 immediately; after release with req_=8'hFF, vld stays 0.
- Fixed priority (RR_EN=0): req_=8'b1111_0101, enb_=0 → the next edge gives vld=1, sel=3'd1, gnt_=8'b1111_1101, multi=1. After ack, with the same req_, line 1 wins again: sel=3'd1.
- Round-robin with wrap (RR_EN=1): req_=8'b0111_1110 (lines 0 and 7) → sel=0; ack → sel=7 (vld stays 1); ack → sel=0 (wrap); ack with req_=8'hFF → vld=0 and gnt_=8'hFF.
- Hold and enable: grant sel=3'd4, then set req_=8'hFF and enb_=1 with ack=0 for 5 cycles → sel=4 and gnt_=8'b1110_1111 stay stable; ack → vld=0. With enb_=1 and req_=8'h00, no grant is issued.
- Back-to-back throughput: req_=8'h00, ack tied high, RR_EN=1 → sel sequence 0,1,2,…,7,0 on consecutive cycles, with vld continuously 1 and multi=1.
- Single request: req_=8'b1101_1111 → sel=3'd5, multi=0, gnt_=8'b1101_1111. Feeding sel into the 3-to-8 decoder with its enable low reproduces gnt_.
